div_frontend: RTL
=================

DIV_FRONTEND -- requirements
Module: div_frontend

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of request/response tag.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: rstn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  request present; req_ready  output  1  request accepted when both high at a clock edge.
REQ-005 req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; req_rs1, req_rs2  input  32  dividend, divisor; req_tag  input  TAG_W.
REQ-006 flush  input  1  discard in-flight operation.
REQ-007 resp_valid  output  1; resp_ready  input  1; resp_data  output  32; resp_tag  output  TAG_W.
REQ-008 Core side: div_enable  output  1; div_is_signed  output  1; div_src, div_sink  output  32; div_completed  input  1; div_quo, div_res  input  32.

Function
REQ-009 States SHALL be IDLE, ISSUE, WAIT, DRAIN, RESP; req_ready SHALL be high only in IDLE.
REQ-010 On accept, SHALL register op, rs1, rs2, tag; div_src/div_sink/div_is_signed SHALL hold the registered values, stable until return to IDLE.
REQ-011 div_is_signed SHALL be 1 for DIV/REM, 0 for DIVU/REMU.
REQ-012 Normal accept: IDLE->ISSUE; div_enable SHALL be high exactly one cycle (ISSUE), then ->WAIT.
REQ-013 div_completed SHALL be sampled only in WAIT/DRAIN; stale high during ISSUE ignored.
REQ-014 WAIT with div_completed high: capture div_quo (DIV/DIVU) or div_res (REM/REMU) into resp_data, ->RESP.
REQ-015 RESP: resp_valid high; resp_data/resp_tag stable while resp_ready low; resp_ready high at edge ->IDLE.
REQ-016 Back-to-back: new request SHALL not be accepted in the same cycle as the response handshake (IDLE required between).
REQ-017 flush in ISSUE or WAIT SHALL ->DRAIN (enable pulse still issued if in ISSUE); DRAIN waits for div_completed, discards result, ->IDLE, no response.
REQ-018 flush in RESP SHALL drop resp_valid next cycle, ->IDLE; flush in IDLE/DRAIN SHALL have no effect; flush has priority over simultaneous completion or handshake.
REQ-019 Nominal latency: accept at edge N, div_enable in cycle N+1, resp_valid after the edge at which div_completed is sampled high.

Reset
REQ-020 rstn low SHALL asynchronously force IDLE, req_ready=1 after release, resp_valid=0, div_enable=0, resp_data=0, resp_tag=0, div_src=0, div_sink=0, div_is_signed=0.
REQ-021 Reset mid-operation SHALL abandon the operation with no response; the core is reset alongside and no drain is performed.

Configuration
REQ-022 Macro DIV_SPECIAL_CASE_EN, when defined, SHALL resolve special cases without the core: accept ->RESP next cycle, div_enable never asserted.
REQ-023 Special cases (RV32M): rs2=0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU rs1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0.
REQ-024 Without DIV_SPECIAL_CASE_EN, all requests SHALL go through ISSUE/WAIT and the core result is returned unmodified.

Verification
REQ-025 DIV rs1=0xFFFFFFF9 (-7), rs2=2, tag 3; core completes 34 cycles later with quo=0xFFFFFFFD, res=0xFFFFFFFF -> single div_enable pulse, resp_data=0xFFFFFFFD, resp_tag=3.
REQ-026 REMU rs1=100, rs2=7, resp_ready held low 5 cycles -> resp_data=2 held stable, resp_valid high all 5 cycles, req_ready low until handshake.
REQ-027 With DIV_SPECIAL_CASE_EN: DIVU rs1=5, rs2=0 -> resp_valid cycle after accept, resp_data=0xFFFFFFFF, div_enable never high; REM 0x80000000 % 0xFFFFFFFF -> 0.
REQ-028 flush asserted in WAIT, core completes 10 cycles later -> no resp_valid, req_ready high the cycle after completion sampled.
REQ-029 rstn pulled low in WAIT (async, mid-cycle) -> resp_valid=0, div_enable=0 immediately; after release, new DIV 10/3 returns 3.
REQ-030 div_completed held high from previous op through ISSUE -> not taken as completion; result captured only on completion sampled in WAIT.

Source files
------------

// File: rtl/div_frontend.sv
// rtl/div_frontend.sv - request/response front end for an iterative divider core (optional DIV_SPECIAL_CASE_EN)
module div_frontend #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             div_enable,
  output logic             div_is_signed,
  output logic [31:0]      div_src,
  output logic [31:0]      div_sink,
  input  logic             div_completed,
  input  logic [31:0]      div_quo,
  input  logic [31:0]      div_res
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_capture;
  logic               w_special;
  logic [31:0]        w_special_data;

  logic [31:0]        r_rs1;
  logic [31:0]        r_rs2;
  logic [TAG_W-1:0]   r_tag;
  logic               r_signed;
  logic               r_is_rem;
  logic [31:0]        r_data;

`ifdef DIV_SPECIAL_CASE_EN
  // Divide-by-zero and signed overflow are answered here without the core
  always_comb begin
    w_special      = 1'b0;
    w_special_data = 32'h0;
    if (req_rs2 == 32'h0) begin
      w_special      = 1'b1;
      w_special_data = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (!req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF)) begin
      w_special      = 1'b1;
      w_special_data = req_op[1] ? 32'h0 : 32'h8000_0000;
    end
  end
`else
  assign w_special      = 1'b0;
  assign w_special_data = 32'h0;
`endif

  // State register; reset abandons any operation outright
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush outranks completion and the response handshake
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = w_special ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // div_completed is not looked at here: a level left over from the
        // previous operation must not be mistaken for this one finishing
        w_next = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          w_next = S_DRAIN;
        end else if (div_completed) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_DRAIN: begin
        if (div_completed) begin
          w_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/tag capture on accept and result capture on completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rs1    <= 32'h0;
      r_rs2    <= 32'h0;
      r_tag    <= '0;
      r_signed <= 1'b0;
      r_is_rem <= 1'b0;
      r_data   <= 32'h0;
    end else begin
      if (w_accept) begin
        r_rs1    <= req_rs1;
        r_rs2    <= req_rs2;
        r_tag    <= req_tag;
        r_signed <= ~req_op[0];
        r_is_rem <= req_op[1];
        if (w_special) begin
          r_data <= w_special_data;
        end
      end else if (w_capture) begin
        r_data <= r_is_rem ? div_res : div_quo;
      end
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign div_enable    = (r_state == S_ISSUE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_data     = r_data;
  assign resp_tag      = r_tag;
  assign div_src       = r_rs1;
  assign div_sink      = r_rs2;
  assign div_is_signed = r_signed;

endmodule
